adder_misr_checker: RTL

//   Output-response analyser for the N-bit ripple adder under test. It

---
 rtl/adder_misr_checker_pkg.sv | 15 +
 rtl/adder_misr_checker_misr_reg.sv | 34 +++
 rtl/adder_misr_checker.sv | 116 +++++++++++
 3 files changed

// File: rtl/adder_misr_checker_pkg.sv
// Shared definitions for the adder BIST response path: FSM states and defaults.
package adder_misr_checker_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } state_t;

  localparam int unsigned DEF_N        = 16;
  localparam int unsigned DEF_PATTERNS = 256;
  localparam logic [16:0] DEF_POLY     = 17'h00009;
  localparam int unsigned COUNT_W      = 16;

endpackage

// File: rtl/adder_misr_checker_misr_reg.sv
// Generic multiple-input signature register: shift left, feed back POLY when
// the MSB falls out, and XOR in the parallel input word.
module misr_reg #(
  parameter int unsigned    W    = 17,
  parameter logic [W-1:0]   POLY = '0,
  parameter logic [W-1:0]   SEED = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] sig
);

  logic [W-1:0] sig_next;

  // Next signature from the current contents and the incoming word
  always_comb begin
    sig_next = {sig[W-2:0], 1'b0} ^ (sig[W-1] ? POLY : '0) ^ d;
  end

  // Signature register: reset/load to SEED, otherwise compact when enabled
  always_ff @(posedge clk) begin
    if (rst) begin
      sig <= SEED;
    end else if (load) begin
      sig <= SEED;
    end else if (en) begin
      sig <= sig_next;
    end
  end

endmodule

// File: rtl/adder_misr_checker.sv
// Response analyser for the ripple adder under test: compacts {co, sum} into
// a MISR over PATTERNS valid responses and compares against GOLDEN.
module adder_misr_checker
  import adder_misr_checker_pkg::*;
#(
  parameter int unsigned  N        = DEF_N,
  parameter int unsigned  PATTERNS = DEF_PATTERNS,
  parameter logic [N:0]   POLY     = DEF_POLY,
  parameter logic [N:0]   SEED     = '0,
  parameter logic [N:0]   GOLDEN   = '0
) (
  input  logic               pin_clk,
  input  logic               pin_rst,
  input  logic               pin_start,
  input  logic               pin_valid,
  input  logic [N-1:0]       pin_sum,
  input  logic               pin_co,
  output logic               pin_busy,
  output logic               pin_done,
  output logic               pin_pass,
  output logic [N:0]         pin_signature,
  output logic [COUNT_W-1:0] pin_count
);

  if (PATTERNS < 1 || PATTERNS > 65535) begin : g_bad_patterns
    $error("adder_misr_checker: PATTERNS must be in 1..65535");
  end

  localparam logic [COUNT_W-1:0] LAST = COUNT_W'(PATTERNS - 1);

  state_t             state;
  state_t             state_next;
  logic [N:0]         d;
  logic [N:0]         sig_upd;
  logic               start_ok;
  logic               capture;
  logic               last;
  logic [COUNT_W-1:0] count;
  logic               pass_q;

  assign d        = {pin_co, pin_sum};
  assign start_ok = pin_start && (state != ST_RUN);
  assign capture  = (state == ST_RUN) && pin_valid;
  assign last     = capture && (count == LAST);

  // Post-update signature, needed so pass can be registered on the same edge
  // that captures the final response
  always_comb begin
    sig_upd = {pin_signature[N-1:0], 1'b0} ^ (pin_signature[N] ? POLY : '0) ^ d;
  end

  misr_reg #(
    .W    (N + 1),
    .POLY (POLY),
    .SEED (SEED)
  ) u_misr (
    .clk  (pin_clk),
    .rst  (pin_rst),
    .load (start_ok),
    .en   (capture),
    .d    (d),
    .sig  (pin_signature)
  );

  // State register
  always_ff @(posedge pin_clk) begin
    if (pin_rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (pin_start) state_next = ST_RUN;
      ST_RUN:  if (last)      state_next = ST_DONE;
      ST_DONE: if (pin_start) state_next = ST_RUN;
      default:                state_next = ST_IDLE;
    endcase
  end

  // State-decoded outputs
  always_comb begin
    pin_busy = (state == ST_RUN);
    pin_done = (state == ST_DONE);
  end

  // Response counter: cleared on start, advanced per compacted response
  always_ff @(posedge pin_clk) begin
    if (pin_rst) begin
      count <= '0;
    end else if (start_ok) begin
      count <= '0;
    end else if (capture) begin
      count <= count + 1'b1;
    end
  end

  // Pass flag: cleared on start, judged from the final post-update signature
  always_ff @(posedge pin_clk) begin
    if (pin_rst) begin
      pass_q <= 1'b0;
    end else if (start_ok) begin
      pass_q <= 1'b0;
    end else if (last) begin
      pass_q <= (sig_upd == GOLDEN);
    end
  end

  assign pin_pass  = pass_q;
  assign pin_count = count;

endmodule
